// File: rtl/layer_output_serializer_if.sv
// rtl/layer_output_serializer_if.sv - parallel neuron bundle in, serial word stream out
interface layer_output_serializer_if #(
    parameter int NN        = 30,
    parameter int dataWidth = 16
);
    logic [NN-1:0]           i_valid;
    logic [NN*dataWidth-1:0] i_data;
    logic                    o_ready;
    logic                    o_valid;
    logic [dataWidth-1:0]    o_data;
    logic                    o_last;
    logic                    busy;
    logic                    overrun;

    // master: upstream layer plus downstream consumer; slave: the serializer
    modport master (
        output i_valid, i_data, o_ready,
        input  o_valid, o_data, o_last, busy, overrun
    );

    modport slave (
        input  i_valid, i_data, o_ready,
        output o_valid, o_data, o_last, busy, overrun
    );
endinterface

// File: rtl/layer_output_serializer.sv
// rtl/layer_output_serializer.sv - captures NN parallel neuron words and replays them serially
module layer_output_serializer #(
    parameter int NN        = 30,
    parameter int dataWidth = 16
) (
    input logic                     clk,
    input logic                     rst,
    layer_output_serializer_if.slave bus
);
    localparam int            CW   = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [CW-1:0] LAST = CW'(NN - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                  state;
    logic [NN*dataWidth-1:0] shreg;
    logic [CW-1:0]           count;
    logic                    last_q;
    logic                    overrun_q;
    logic                    frame;
    logic                    beat;

    assign frame = &bus.i_valid;
    assign beat  = (state == SHIFT) && bus.o_ready;

    // o_last is kept as its own flop so it tracks count without a decode on the output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shreg     <= '0;
            count     <= '0;
            last_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame) begin
                        shreg  <= bus.i_data;
                        count  <= '0;
                        last_q <= (NN == 1);
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (beat) begin
                        if (count == LAST) begin
                            if (frame) begin
                                // back-to-back: next frame starts with no idle cycle
                                shreg  <= bus.i_data;
                                count  <= '0;
                                last_q <= (NN == 1);
                            end else begin
                                shreg  <= shreg >> dataWidth;
                                count  <= '0;
                                last_q <= 1'b0;
                                state  <= IDLE;
                            end
                        end else begin
                            shreg  <= shreg >> dataWidth;
                            count  <= count + CW'(1);
                            last_q <= ((count + CW'(1)) == LAST);
                            if (frame) begin
                                overrun_q <= 1'b1;
                            end
                        end
                    end else if (frame) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_valid = (state == SHIFT);
    assign bus.busy    = (state == SHIFT);
    assign bus.o_data  = shreg[dataWidth-1:0];
    assign bus.o_last  = last_q;
    assign bus.overrun = overrun_q;
endmodule
